// File: rtl/ctrl_encode_def_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
// States, instruction classes, strobe codes and opcode values.
package ctrl_encode_def_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_I, C_LW, C_SW,
    C_BEQ, C_BNE, C_J, C_JAL,
    C_ILL
  } iclass_e;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;
  localparam logic [3:0] ALU_NOR  = 4'd9;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  localparam logic [1:0] GPR_RD = 2'b00;
  localparam logic [1:0] GPR_RT = 2'b01;
  localparam logic [1:0] GPR_31 = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Instruction classifier for the multi-cycle controller.
// Maps Op/Funct to class, execute-stage ALUOp and EXTOp.
module mc_decode
  import ctrl_encode_def_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_e    cls,
  output logic [3:0] alu_op,
  output logic       ext_op,
  output logic       illegal
);

  // Decode opcode, then funct for R-type; unknown encodings are illegal
  always_comb begin
    cls    = C_ILL;
    alu_op = ALU_NOP;
    ext_op = 1'b0;
    unique case (op)
      OP_R: begin
        cls = C_R;
        unique case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL:  alu_op = ALU_SLL;
          default: cls = C_ILL;
        endcase
      end
      OP_ADDI: begin
        cls    = C_I;
        alu_op = ALU_ADD;
        ext_op = 1'b1;
      end
      OP_SLTI: begin
        cls    = C_I;
        alu_op = ALU_SLT;
        ext_op = 1'b1;
      end
      OP_ORI: begin
        cls    = C_I;
        alu_op = ALU_OR;
      end
      OP_LUI: begin
        cls    = C_I;
        alu_op = ALU_LUI;
      end
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_BNE:  cls = C_BNE;
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_ILL;
    endcase
    illegal = (cls == C_ILL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM.
// Sequences fetch/decode/execute/mem/wb over a shared memory port.
module multicycle_ctrl
  import ctrl_encode_def_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] NPCOp,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       EXTOp,
  output logic       ALUSrc,
  output logic [3:0] ALUOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic       illegal
);

  state_e     state_q;
  state_e     state_d;
  iclass_e    cls;
  logic [3:0] dec_alu;
  logic       dec_ext;
  logic       dec_ill;

  mc_decode u_dec (
    .op      (Op),
    .funct   (Funct),
    .cls     (cls),
    .alu_op  (dec_alu),
    .ext_op  (dec_ext),
    .illegal (dec_ill)
  );

  // State register; reset returns to FETCH
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next state and per-state strobes; everything held low in reset
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    NPCOp    = NPC_PLUS4;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = ALU_NOP;
    GPRSel   = GPR_RD;
    WDSel    = WD_ALU;
    illegal  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_rdy) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          unique case (cls)
            C_R:          state_d = S_EXEC_R;
            C_I:          state_d = S_EXEC_I;
            C_LW, C_SW:   state_d = S_MEMADR;
            C_BEQ, C_BNE: state_d = S_BRANCH;
            C_J, C_JAL:   state_d = S_JUMP;
            default: begin
              illegal = dec_ill;
              state_d = S_FETCH;
            end
          endcase
        end
        S_EXEC_R: begin
          ALUOp   = dec_alu;
          state_d = S_ALUWB;
        end
        S_EXEC_I: begin
          ALUOp   = dec_alu;
          ALUSrc  = 1'b1;
          EXTOp   = dec_ext;
          state_d = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          GPRSel   = (cls == C_R) ? GPR_RD : GPR_RT;
          state_d  = S_FETCH;
        end
        S_MEMADR: begin
          ALUOp   = ALU_ADD;
          ALUSrc  = 1'b1;
          EXTOp   = 1'b1;
          state_d = (cls == C_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
          if (mem_rdy) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          WDSel    = WD_MEM;
          GPRSel   = GPR_RT;
          state_d  = S_FETCH;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemWrite = 1'b1;
          if (mem_rdy) state_d = S_FETCH;
        end
        S_BRANCH: begin
          ALUOp   = ALU_SUB;
          NPCOp   = NPC_BRANCH;
          PCWrite = ((cls == C_BEQ) & Zero) |
                    ((cls == C_BNE) & ~Zero);
          state_d = S_FETCH;
        end
        S_JUMP: begin
          PCWrite = 1'b1;
          NPCOp   = NPC_JUMP;
          if (cls == C_JAL) begin
            RegWrite = 1'b1;
            GPRSel   = GPR_31;
            WDSel    = WD_PC;
          end
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl.
// Per-cycle expected strobe vectors are hand-derived.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_rdy;
  logic       mem_req, IorD, IRWrite, PCWrite;
  logic [1:0] NPCOp;
  logic       RegWrite, MemWrite, EXTOp, ALUSrc;
  logic [3:0] ALUOp;
  logic [1:0] GPRSel, WDSel;
  logic       illegal;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .Op       (Op),
    .Funct    (Funct),
    .Zero     (Zero),
    .mem_rdy  (mem_rdy),
    .mem_req  (mem_req),
    .IorD     (IorD),
    .IRWrite  (IRWrite),
    .PCWrite  (PCWrite),
    .NPCOp    (NPCOp),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .EXTOp    (EXTOp),
    .ALUSrc   (ALUSrc),
    .ALUOp    (ALUOp),
    .GPRSel   (GPRSel),
    .WDSel    (WDSel),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  logic [18:0] outs;
  assign outs = {mem_req, IorD, IRWrite, PCWrite, NPCOp,
                 RegWrite, MemWrite, EXTOp, ALUSrc, ALUOp,
                 GPRSel, WDSel, illegal};

  function automatic logic [18:0] ov(
    input logic req, iord, irw, pcw,
    input logic [1:0] npc,
    input logic rw, mw, ext, src,
    input logic [3:0] alu,
    input logic [1:0] gpr, wd,
    input logic ill);
    return {req, iord, irw, pcw, npc, rw, mw, ext, src,
            alu, gpr, wd, ill};
  endfunction

  localparam logic [18:0] F_RDY =
    19'b1_0_1_1_00_0_0_0_0_0000_00_00_0;
  localparam logic [18:0] F_WAIT =
    19'b1_0_0_0_00_0_0_0_0_0000_00_00_0;
  localparam logic [18:0] IDLE = 19'd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_rdy = 1'b1;
    Op = 6'h3F;
    #1;
    checks++;
    if (outs !== IDLE) begin
      errors++;
      $display("FAIL reset_outs: got %h want %h", outs, IDLE);
    end
    step();
    rst = 1'b0;
    mem_rdy = 1'b0;
    #1;
    checks++;
    if (outs !== F_WAIT) begin
      errors++;
      $display("FAIL reset_first_req: got %h want %h", outs, F_WAIT);
    end
    step();
    #1;
    checks++;
    if (outs !== F_WAIT) begin
      errors++;
      $display("FAIL fetch_wait_hold: got %h want %h", outs, F_WAIT);
    end
  endtask

  task automatic test_add();
    logic        r [4];
    logic [18:0] e [4];
    Op = 6'h00;
    Funct = 6'h20;
    r = '{1'b1, 1'b1, 1'b1, 1'b1};
    e[0] = F_RDY;
    e[1] = IDLE;
    e[2] = ov(0,0,0,0,2'b00,0,0,0,0,4'd1,2'b00,2'b00,0);
    e[3] = ov(0,0,0,0,2'b00,1,0,0,0,4'd0,2'b00,2'b00,0);
    for (int i = 0; i < 4; i++) begin
      mem_rdy = r[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL add_c%0d: got %h want %h", i, outs, e[i]);
      end
      step();
    end
  endtask

  task automatic test_itype();
    logic [18:0] e [8];
    Op = 6'h0D;
    Funct = 6'h00;
    e[0] = F_RDY;
    e[1] = IDLE;
    e[2] = ov(0,0,0,0,2'b00,0,0,0,1,4'd4,2'b00,2'b00,0);
    e[3] = ov(0,0,0,0,2'b00,1,0,0,0,4'd0,2'b01,2'b00,0);
    e[4] = F_RDY;
    e[5] = IDLE;
    e[6] = ov(0,0,0,0,2'b00,0,0,1,1,4'd1,2'b00,2'b00,0);
    e[7] = ov(0,0,0,0,2'b00,1,0,0,0,4'd0,2'b01,2'b00,0);
    mem_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) Op = 6'h08;
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL itype_c%0d: got %h want %h", i, outs, e[i]);
      end
      step();
    end
  endtask

  task automatic test_lw_stall();
    logic        r [7];
    logic [18:0] e [7];
    Op = 6'h23;
    r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    e[0] = F_RDY;
    e[1] = IDLE;
    e[2] = ov(0,0,0,0,2'b00,0,0,1,1,4'd1,2'b00,2'b00,0);
    e[3] = ov(1,1,0,0,2'b00,0,0,0,0,4'd0,2'b00,2'b00,0);
    e[4] = e[3];
    e[5] = e[3];
    e[6] = ov(0,0,0,0,2'b00,1,0,0,0,4'd0,2'b01,2'b01,0);
    for (int i = 0; i < 7; i++) begin
      mem_rdy = r[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL lw_c%0d: got %h want %h", i, outs, e[i]);
      end
      step();
    end
  endtask

  task automatic test_branch();
    logic [5:0]  op_t [3];
    logic        z_t  [3];
    logic [18:0] eb   [3];
    op_t = '{6'h04, 6'h05, 6'h05};
    z_t  = '{1'b1, 1'b1, 1'b0};
    eb[0] = ov(0,0,0,1,2'b01,0,0,0,0,4'd2,2'b00,2'b00,0);
    eb[1] = ov(0,0,0,0,2'b01,0,0,0,0,4'd2,2'b00,2'b00,0);
    eb[2] = eb[0];
    mem_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      Op = op_t[k];
      Zero = z_t[k];
      #1;
      checks++;
      if (outs !== F_RDY) begin
        errors++;
        $display("FAIL br%0d_fetch: got %h want %h", k, outs, F_RDY);
      end
      step();
      #1;
      checks++;
      if (outs !== IDLE) begin
        errors++;
        $display("FAIL br%0d_decode: got %h want %h", k, outs, IDLE);
      end
      step();
      #1;
      checks++;
      if (outs !== eb[k]) begin
        errors++;
        $display("FAIL br%0d_exec: got %h want %h", k, outs, eb[k]);
      end
      step();
    end
    Zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [5:0]  op_t [2];
    logic [18:0] ej   [2];
    op_t = '{6'h03, 6'h02};
    ej[0] = ov(0,0,0,1,2'b10,1,0,0,0,4'd0,2'b10,2'b10,0);
    ej[1] = ov(0,0,0,1,2'b10,0,0,0,0,4'd0,2'b00,2'b00,0);
    mem_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      Op = op_t[k];
      step();
      step();
      #1;
      checks++;
      if (outs !== ej[k]) begin
        errors++;
        $display("FAIL jump%0d: got %h want %h", k, outs, ej[k]);
      end
      step();
    end
  endtask

  task automatic test_illegal();
    logic [5:0]  op_t [2];
    logic [5:0]  fn_t [2];
    logic [18:0] ei;
    op_t = '{6'h3F, 6'h00};
    fn_t = '{6'h00, 6'h3F};
    ei = ov(0,0,0,0,2'b00,0,0,0,0,4'd0,2'b00,2'b00,1);
    for (int k = 0; k < 2; k++) begin
      Op = op_t[k];
      Funct = fn_t[k];
      mem_rdy = 1'b1;
      step();
      mem_rdy = 1'b0;
      #1;
      checks++;
      if (outs !== ei) begin
        errors++;
        $display("FAIL illegal%0d_decode: got %h want %h", k, outs, ei);
      end
      step();
      #1;
      checks++;
      if (outs !== F_WAIT) begin
        errors++;
        $display("FAIL illegal%0d_ret: got %h want %h", k, outs, F_WAIT);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    logic [18:0] ew;
    ew = ov(1,1,0,0,2'b00,0,1,0,0,4'd0,2'b00,2'b00,0);
    Op = 6'h2B;
    mem_rdy = 1'b1;
    step();
    step();
    step();
    mem_rdy = 1'b0;
    #1;
    checks++;
    if (outs !== ew) begin
      errors++;
      $display("FAIL sw_wait: got %h want %h", outs, ew);
    end
    step();
    #1;
    checks++;
    if (outs !== ew) begin
      errors++;
      $display("FAIL sw_wait_hold: got %h want %h", outs, ew);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== IDLE) begin
      errors++;
      $display("FAIL sw_rst_drop: got %h want %h", outs, IDLE);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== F_WAIT) begin
      errors++;
      $display("FAIL sw_rst_fetch: got %h want %h", outs, F_WAIT);
    end
  endtask

  initial begin
    rst = 1'b1;
    Op = 6'h00;
    Funct = 6'h00;
    Zero = 1'b0;
    mem_rdy = 1'b0;
    step();
    step();
    test_reset();
    test_add();
    test_itype();
    test_lw_stall();
    test_branch();
    test_jump();
    test_illegal();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
